// File: rtl/vic_ctrl.sv
// Vectored-interrupt controller front end: accepts a VIC request, flushes the pipeline,
// jumps to the ISR vector and restores the return PC on reti. Optional macro: VIC_CCODES_SAVE_EN.
module vic_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_PC,
  input  logic        i_PC_stall,
  input  logic        i_reti,
  input  logic [31:0] i_ISR_addr,
  input  logic        i_IRQ,
  input  logic [3:0]  i_CCodes,
  output logic        o_IRQ_PC,
  output logic [31:0] o_VIC_iaddr,
  output logic [3:0]  o_VIC_CCodes,
  output logic        o_IRQ_VIC,
  output logic        o_IRQ_Flush_ctrl
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    JUMP  = 3'd2,
    ISR   = 3'd3,
    RET   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] isr_reg_q, isr_reg_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [3:0]  cnt_q, cnt_d;

  // Requests arriving outside IDLE are simply dropped; the VIC must re-request.
  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    isr_reg_d = isr_reg_q;
    ret_pc_d  = ret_pc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_IRQ) begin
          isr_reg_d = i_ISR_addr;
          ret_pc_d  = i_PC;
          cnt_d     = 4'(FLUSH_CYCLES);
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        if (!i_PC_stall) begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = JUMP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      JUMP: begin
        if (!i_PC_stall) state_d = ISR;
      end
      ISR: begin
        if (i_reti) state_d = RET;
      end
      RET: begin
        if (!i_PC_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      isr_reg_q <= 32'h0;
      ret_pc_q  <= 32'h0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      isr_reg_q <= isr_reg_d;
      ret_pc_q  <= ret_pc_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef VIC_CCODES_SAVE_EN
  logic [3:0] cc_reg_q;

  // Condition codes are held until the next accepted request overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_reg_q <= 4'h0;
    end else if (state_q == IDLE && i_IRQ) begin
      cc_reg_q <= i_CCodes;
    end
  end

  assign o_VIC_CCodes = cc_reg_q;
`else
  logic unused_ccodes;
  assign unused_ccodes = ^i_CCodes;
  assign o_VIC_CCodes  = 4'b0000;
`endif

  // Outputs depend only on registered state and data.
  always_comb begin
    o_IRQ_PC         = 1'b0;
    o_VIC_iaddr      = 32'h0;
    o_IRQ_VIC        = 1'b1;
    o_IRQ_Flush_ctrl = 1'b0;
    unique case (state_q)
      IDLE:  o_IRQ_VIC = 1'b0;
      FLUSH: o_IRQ_Flush_ctrl = 1'b1;
      JUMP: begin
        o_IRQ_PC    = 1'b1;
        o_VIC_iaddr = isr_reg_q;
      end
      ISR: ;
      RET: begin
        o_IRQ_PC         = 1'b1;
        o_VIC_iaddr      = ret_pc_q;
        o_IRQ_Flush_ctrl = 1'b1;
      end
      default: o_IRQ_VIC = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_vic_ctrl.sv
// Directed self-checking bench for vic_ctrl; expected values are hand-derived per step.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_vic_ctrl;

`ifdef VIC_CCODES_SAVE_EN
  localparam bit CC_ON = 1'b1;
`else
  localparam bit CC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_PC = 32'h0;
  logic        i_PC_stall = 1'b0;
  logic        i_reti = 1'b0;
  logic [31:0] i_ISR_addr = 32'h0;
  logic        i_IRQ = 1'b0;
  logic [3:0]  i_CCodes = 4'h0;
  logic        o_IRQ_PC;
  logic [31:0] o_VIC_iaddr;
  logic [3:0]  o_VIC_CCodes;
  logic        o_IRQ_VIC;
  logic        o_IRQ_Flush_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  vic_ctrl #(.FLUSH_CYCLES(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_PC             (i_PC),
    .i_PC_stall       (i_PC_stall),
    .i_reti           (i_reti),
    .i_ISR_addr       (i_ISR_addr),
    .i_IRQ            (i_IRQ),
    .i_CCodes         (i_CCodes),
    .o_IRQ_PC         (o_IRQ_PC),
    .o_VIC_iaddr      (o_VIC_iaddr),
    .o_VIC_CCodes     (o_VIC_CCodes),
    .o_IRQ_VIC        (o_IRQ_VIC),
    .o_IRQ_Flush_ctrl (o_IRQ_Flush_ctrl)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ecc(input logic [3:0] v);
    return CC_ON ? v : 4'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fields: {irq_pc, iaddr, ccodes, irq_vic, flush}
  task automatic chk(input string tag, input logic pc, input logic [31:0] ia,
                     input logic [3:0] cc, input logic vic, input logic fl);
    logic [38:0] obs, exp;
    obs = {o_IRQ_PC, o_VIC_iaddr, o_VIC_CCodes, o_IRQ_VIC, o_IRQ_Flush_ctrl};
    exp = {pc, ia, cc, vic, fl};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed pc=%b ia=%h cc=%h vic=%b fl=%b expected pc=%b ia=%h cc=%h vic=%b fl=%b",
             tag, obs[38], obs[37:6], obs[5:2], obs[1], obs[0], pc, ia, cc, vic, fl);
    end
  endtask

  initial begin
    // Reset and quiet idle period
    tick();
    chk("reset", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_quiet", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    end

    // Single IRQ; inputs scrambled after acceptance to prove latching
    i_PC = 32'hFFFF_FFFF; i_ISR_addr = 32'h1111_1111; i_CCodes = 4'hF; i_IRQ = 1'b1;
    tick();
    i_IRQ = 1'b0; i_PC = 32'h0; i_ISR_addr = 32'h0; i_CCodes = 4'h0;
    chk("flush1", 1'b0, 32'h0, ecc(4'hF), 1'b1, 1'b1);
    tick(); chk("flush2", 1'b0, 32'h0, ecc(4'hF), 1'b1, 1'b1);
    tick(); chk("flush3", 1'b0, 32'h0, ecc(4'hF), 1'b1, 1'b1);
    tick(); chk("jump1", 1'b1, 32'h1111_1111, ecc(4'hF), 1'b1, 1'b0);
    tick(); chk("isr1", 1'b0, 32'h0, ecc(4'hF), 1'b1, 1'b0);
    tick(); chk("isr1_hold", 1'b0, 32'h0, ecc(4'hF), 1'b1, 1'b0);

    // Return from interrupt, then reti in IDLE is ignored
    i_reti = 1'b1; tick(); i_reti = 1'b0;
    chk("ret1", 1'b1, 32'hFFFF_FFFF, ecc(4'hF), 1'b1, 1'b1);
    tick(); chk("idle_after_ret1", 1'b0, 32'h0, ecc(4'hF), 1'b0, 1'b0);
    i_reti = 1'b1; tick(); i_reti = 1'b0;
    chk("reti_in_idle", 1'b0, 32'h0, ecc(4'hF), 1'b0, 1'b0);

    // Back-to-back interrupt #1 at 2222_2222, with an ignored IRQ during ISR
    i_PC = 32'h1234_5678; i_ISR_addr = 32'h2222_2222; i_CCodes = 4'h5; i_IRQ = 1'b1;
    tick(); i_IRQ = 1'b0;
    chk("b2b1_flush", 1'b0, 32'h0, ecc(4'h5), 1'b1, 1'b1);
    tick(); tick(); tick();
    chk("b2b1_jump", 1'b1, 32'h2222_2222, ecc(4'h5), 1'b1, 1'b0);
    tick(); chk("b2b1_isr", 1'b0, 32'h0, ecc(4'h5), 1'b1, 1'b0);
    i_ISR_addr = 32'h9999_9999; i_CCodes = 4'h9; i_IRQ = 1'b1;
    tick(); i_IRQ = 1'b0;
    chk("irq_in_isr_ignored", 1'b0, 32'h0, ecc(4'h5), 1'b1, 1'b0);
    tick(); chk("isr_still", 1'b0, 32'h0, ecc(4'h5), 1'b1, 1'b0);
    i_reti = 1'b1; tick(); i_reti = 1'b0;
    chk("b2b1_ret", 1'b1, 32'h1234_5678, ecc(4'h5), 1'b1, 1'b1);
    tick(); chk("b2b1_idle", 1'b0, 32'h0, ecc(4'h5), 1'b0, 1'b0);

    // Back-to-back interrupt #2 at 3333_3333; IRQ and reti together in ISR
    i_PC = 32'hA5A5_A5A5; i_ISR_addr = 32'h3333_3333; i_CCodes = 4'hA; i_IRQ = 1'b1;
    tick(); i_IRQ = 1'b0;
    chk("b2b2_flush", 1'b0, 32'h0, ecc(4'hA), 1'b1, 1'b1);
    tick(); tick(); tick();
    chk("b2b2_jump", 1'b1, 32'h3333_3333, ecc(4'hA), 1'b1, 1'b0);
    tick(); chk("b2b2_isr", 1'b0, 32'h0, ecc(4'hA), 1'b1, 1'b0);
    i_IRQ = 1'b1; i_reti = 1'b1;
    tick(); i_reti = 1'b0;
    chk("irq_reti_ret", 1'b1, 32'hA5A5_A5A5, ecc(4'hA), 1'b1, 1'b1);
    tick(); i_IRQ = 1'b0;
    chk("irq_in_ret_dropped", 1'b0, 32'h0, ecc(4'hA), 1'b0, 1'b0);
    tick(); chk("idle_no_requeue", 1'b0, 32'h0, ecc(4'hA), 1'b0, 1'b0);

    // Stall during FLUSH stretches it to 5 cycles; stall holds JUMP and RET
    i_PC = 32'h5555_5555; i_ISR_addr = 32'h4444_4444; i_CCodes = 4'h3; i_IRQ = 1'b1;
    tick(); i_IRQ = 1'b0;
    chk("stall_f1", 1'b0, 32'h0, ecc(4'h3), 1'b1, 1'b1);
    i_PC_stall = 1'b1;
    tick(); chk("stall_f2", 1'b0, 32'h0, ecc(4'h3), 1'b1, 1'b1);
    tick(); chk("stall_f3", 1'b0, 32'h0, ecc(4'h3), 1'b1, 1'b1);
    i_PC_stall = 1'b0;
    tick(); chk("stall_f4", 1'b0, 32'h0, ecc(4'h3), 1'b1, 1'b1);
    tick(); chk("stall_f5", 1'b0, 32'h0, ecc(4'h3), 1'b1, 1'b1);
    tick(); chk("stall_jump", 1'b1, 32'h4444_4444, ecc(4'h3), 1'b1, 1'b0);
    i_PC_stall = 1'b1;
    tick(); chk("stall_jump_held", 1'b1, 32'h4444_4444, ecc(4'h3), 1'b1, 1'b0);
    i_PC_stall = 1'b0;
    tick(); chk("stall_isr", 1'b0, 32'h0, ecc(4'h3), 1'b1, 1'b0);
    i_reti = 1'b1; i_PC_stall = 1'b1;
    tick(); i_reti = 1'b0;
    chk("stall_ret", 1'b1, 32'h5555_5555, ecc(4'h3), 1'b1, 1'b1);
    tick(); chk("stall_ret_held", 1'b1, 32'h5555_5555, ecc(4'h3), 1'b1, 1'b1);
    i_PC_stall = 1'b0;
    tick(); chk("stall_idle", 1'b0, 32'h0, ecc(4'h3), 1'b0, 1'b0);

    // Reset mid-FLUSH, with priority over a pending IRQ
    i_PC = 32'h7777_7777; i_ISR_addr = 32'h6666_6666; i_CCodes = 4'hC; i_IRQ = 1'b1;
    tick(); i_IRQ = 1'b0;
    chk("rst_f1", 1'b0, 32'h0, ecc(4'hC), 1'b1, 1'b1);
    tick(); chk("rst_f2", 1'b0, 32'h0, ecc(4'hC), 1'b1, 1'b1);
    rst = 1'b1;
    tick(); chk("rst_mid_flush", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    i_IRQ = 1'b1;
    tick(); chk("rst_over_irq", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0; i_IRQ = 1'b0;
    tick(); chk("post_rst_idle", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vic_ctrl.md
VIC_CTRL -- requirements
Module: vic_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 3: number of cycles o_IRQ_Flush_ctrl is asserted before the ISR jump (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_PC, input, 32 bits: pipeline return address, i.e. the oldest uncommitted instruction.
REQ-005 SHALL have port i_PC_stall, input, 1 bit: pipeline stall; freezes controller progress.
REQ-006 SHALL have port i_reti, input, 1 bit: return-from-interrupt executed.
REQ-007 SHALL have port i_ISR_addr, input, 32 bits: vector address supplied by the VIC.
REQ-008 SHALL have port i_IRQ, input, 1 bit: interrupt request from the VIC, sampled at the clock edge.
REQ-009 SHALL have port i_CCodes, input, 4 bits: current condition codes (NZCV).
REQ-010 SHALL have port o_IRQ_PC, output, 1 bit: PC-override select to the fetch stage.
REQ-011 SHALL have port o_VIC_iaddr, output, 32 bits: PC override value.
REQ-012 SHALL have port o_VIC_CCodes, output, 4 bits: condition codes to restore.
REQ-013 SHALL have port o_IRQ_VIC, output, 1 bit: busy / in-service indication to the VIC.
REQ-014 SHALL have port o_IRQ_Flush_ctrl, output, 1 bit: pipeline flush request.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, JUMP, ISR, RET; all outputs are decoded from registered state and registered data, with no combinational input-to-output path.
REQ-016 SHALL, in IDLE with i_IRQ=1 at an edge, latch i_ISR_addr into isr_reg, i_PC into ret_pc, and i_CCodes into cc_reg, load the flush counter with FLUSH_CYCLES, and go to FLUSH.
REQ-017 SHALL ignore i_reti in IDLE.
REQ-018 SHALL assert o_IRQ_Flush_ctrl=1 in FLUSH; the counter decrements each edge with i_PC_stall=0 and holds while i_PC_stall=1; the FSM goes to JUMP when the counter reaches 0.
REQ-019 SHALL drive o_IRQ_PC=1 and o_VIC_iaddr=isr_reg in JUMP; the FSM stays in JUMP while i_PC_stall=1, otherwise goes to ISR on the next edge.
REQ-020 SHALL ignore i_IRQ in ISR (no nesting); on i_reti=1 the FSM goes to RET.
REQ-021 SHALL drive o_IRQ_PC=1, o_VIC_iaddr=ret_pc and o_IRQ_Flush_ctrl=1 in RET; the FSM stays in RET while i_PC_stall=1, otherwise goes to IDLE.
REQ-022 SHALL drive o_IRQ_VIC=1 in FLUSH, JUMP, ISR and RET, and 0 in IDLE.
REQ-023 SHALL drive o_IRQ_PC=0 and o_VIC_iaddr=32'h0 in IDLE, FLUSH and ISR.
REQ-024 SHALL, with i_IRQ and i_reti both high in ISR, take the i_reti transition and drop the IRQ; the VIC must re-request it.
REQ-025 SHALL drop an i_IRQ that arrives in any state other than IDLE, with no queuing.
REQ-026 SHALL pass 32-bit addresses unmodified, with no arithmetic on the PC.

Reset
REQ-027 SHALL, on rst=1 at an edge, enter IDLE from any state (including mid-FLUSH, JUMP or RET) and clear isr_reg, ret_pc, cc_reg and the counter to 0.
REQ-028 SHALL hold all outputs at 0 after reset, until the first accepted IRQ.
REQ-029 SHALL give rst priority over i_IRQ, i_reti and i_PC_stall.

Configuration
REQ-030 SHALL, with macro VIC_CCODES_SAVE_EN defined, capture cc_reg on IRQ acceptance and drive o_VIC_CCodes=cc_reg (registered, held until the next accepted IRQ).
REQ-031 SHALL, without VIC_CCODES_SAVE_EN, contain no cc_reg storage and tie o_VIC_CCodes to 4'b0000.

Verification
REQ-032 SHALL check that, after reset with no IRQ for 20 cycles, all outputs stay 0.
REQ-033 SHALL check that, with i_PC=FFFF_FFFF, i_ISR_addr=1111_1111, i_CCodes=F and a 1-cycle i_IRQ: o_IRQ_VIC=1, o_IRQ_Flush_ctrl=1 for 3 cycles, then 1 cycle of o_IRQ_PC=1 with o_VIC_iaddr=1111_1111, then ISR.
REQ-034 SHALL check that a 1-cycle i_reti in ISR gives 1 cycle of o_IRQ_PC=1 with o_VIC_iaddr=FFFF_FFFF, o_IRQ_Flush_ctrl=1 and o_VIC_CCodes=F (macro on), then IDLE with o_IRQ_VIC=0.
REQ-035 SHALL check that back-to-back interrupts with ISR addresses 2222_2222 then 3333_3333, each followed by i_reti, jump to the correct vector each time, and that an i_IRQ pulse during ISR is ignored.
REQ-036 SHALL check that i_PC_stall=1 for 2 cycles during FLUSH lengthens flush to 5 cycles, and that a stall during JUMP holds o_IRQ_PC=1.
REQ-037 SHALL check that rst asserted during FLUSH returns the block to IDLE with all outputs 0 on the next edge.
